// File: rtl/sub_bytes_iter_if.sv
// Stream interface for sub_bytes_iter: input state handshake, output state handshake
// and the in-flight indicator.
interface sub_bytes_iter_if #(
   parameter int unsigned DATA_W = 128
);
   logic              valid_in;
   logic              ready_in;
   logic              inv_in;
   logic [DATA_W-1:0] data_in;
   logic              valid_out;
   logic              ready_out;
   logic [DATA_W-1:0] data_out;
   logic              busy;

   modport master (
      output valid_in, inv_in, data_in, ready_out,
      input  ready_in, valid_out, data_out, busy
   );

   modport slave (
      input  valid_in, inv_in, data_in, ready_out,
      output ready_in, valid_out, data_out, busy
   );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes / InvSubBytes: LANES bytes of the state substituted per clock,
// NO_BYTES/LANES clocks per block, valid/ready on both sides.
module sub_bytes_iter #(
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned NO_BYTES = DATA_W >> 3,
   parameter int unsigned LANES    = 4
) (
   input  logic            clk,
   input  logic            reset,
   sub_bytes_iter_if.slave bus
);

   localparam int unsigned STEPS = NO_BYTES / LANES;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              inv_q;
   logic              valid_out_q;
   logic [DATA_W-1:0] work_q;
   logic [DATA_W-1:0] data_out_q;

   int unsigned       slice_base;
   logic [7:0]        lane_out [LANES];

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 = (x^127)^2 is the multiplicative inverse in GF(2^8); 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < 6; i++) begin
         r = gf_mul(gf_mul(r, r), x);
      end
      return gf_mul(r, r);
   endfunction

   // Forward and inverse S-box share one field inverter per lane.
   function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
      logic [7:0] pre;
      logic [7:0] y;
      pre = inv ? (rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05) : x;
      y   = gf_inv(pre);
      return inv ? y : (y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63);
   endfunction

   always_comb begin
      slice_base = int'(cnt_q) * LANES;
      for (int l = 0; l < LANES; l++) begin
         lane_out[l] = sbox(work_q[(slice_base + l) * 8 +: 8], inv_q);
      end
   end

   assign bus.ready_in  = (state_q == StIdle) || ((state_q == StDone) && bus.ready_out);
   assign bus.busy      = (state_q == StBusy);
   assign bus.valid_out = valid_out_q;
   assign bus.data_out  = data_out_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         inv_q       <= 1'b0;
         valid_out_q <= 1'b0;
         work_q      <= '0;
         data_out_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.valid_in) begin
                  work_q  <= bus.data_in;
                  inv_q   <= bus.inv_in;
                  cnt_q   <= '0;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               for (int l = 0; l < LANES; l++) begin
                  data_out_q[(slice_base + l) * 8 +: 8] <= lane_out[l];
               end
               if (cnt_q == LAST) begin
                  state_q     <= StDone;
                  valid_out_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (bus.ready_out) begin
                  valid_out_q <= 1'b0;
                  // Output transfer and next accept can share the same edge.
                  if (bus.valid_in) begin
                     work_q  <= bus.data_in;
                     inv_q   <= bus.inv_in;
                     cnt_q   <= '0;
                     state_q <= StBusy;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: three instances (LANES 4, 1, 16) checked against
// hand-computed vectors and a table-based S-box model.
module tb_sub_bytes_iter;

   localparam logic [127:0] In2  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] Out2 = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [127:0] All63 = 128'h63636363636363636363636363636363;
   localparam logic [127:0] InSgl = 128'h0000000000000000000000000000_63ed;
   localparam logic [127:0] OutSgl = 128'h5252525252525252525252525252_0053;

   localparam logic [7:0] SboxTab [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic       clk;
   logic       reset;
   logic [7:0] inv_tab [256];
   int         tests;
   int         fails;

   sub_bytes_iter_if #(.DATA_W(128)) b4 ();
   sub_bytes_iter_if #(.DATA_W(128)) b1 ();
   sub_bytes_iter_if #(.DATA_W(128)) b16 ();

   sub_bytes_iter #(.DATA_W(128), .LANES(4))  dut4  (.clk(clk), .reset(reset), .bus(b4));
   sub_bytes_iter #(.DATA_W(128), .LANES(1))  dut1  (.clk(clk), .reset(reset), .bus(b1));
   sub_bytes_iter #(.DATA_W(128), .LANES(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i*8 +: 8] = inv ? inv_tab[d[i*8 +: 8]] : SboxTab[d[i*8 +: 8]];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic get_valid(input int sel);
      case (sel)
         0:       return b4.valid_out;
         1:       return b1.valid_out;
         default: return b16.valid_out;
      endcase
   endfunction

   function automatic logic [127:0] get_data(input int sel);
      case (sel)
         0:       return b4.data_out;
         1:       return b1.data_out;
         default: return b16.data_out;
      endcase
   endfunction

   task automatic drive(input int sel, input logic v, input logic inv, input logic [127:0] d);
      case (sel)
         0:       begin b4.valid_in = v;  b4.inv_in = inv;  b4.data_in = d;  end
         1:       begin b1.valid_in = v;  b1.inv_in = inv;  b1.data_in = d;  end
         default: begin b16.valid_in = v; b16.inv_in = inv; b16.data_in = d; end
      endcase
   endtask

   task automatic set_ready_out(input int sel, input logic r);
      case (sel)
         0:       b4.ready_out = r;
         1:       b1.ready_out = r;
         default: b16.ready_out = r;
      endcase
   endtask

   // Counts edges until valid_out; a missing response shows up as latency 40.
   task automatic wait_valid(input int sel, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (get_valid(sel)) break;
      end
   endtask

   // Accepts one block, flips inv_in right after accept, and waits for the result.
   task automatic run_block(input int sel, input logic [127:0] d, input logic inv,
                            output logic [127:0] dout, output int lat);
      drive(sel, 1'b1, inv, d);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, ~inv, '0);
      wait_valid(sel, lat);
      dout = get_data(sel);
   endtask

   task automatic consume(input int sel);
      set_ready_out(sel, 1'b1);
      @(posedge clk);
      #1;
      set_ready_out(sel, 1'b0);
   endtask

   initial begin
      logic [127:0] dout;
      logic [127:0] d;
      int           lat;
      tests = 0;
      fails = 0;
      for (int i = 0; i < 256; i++) inv_tab[SboxTab[i]] = 8'(i);
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         drive(s, 1'b0, 1'b0, '0);
         set_ready_out(s, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset state
      check("rst_ready_in", 128'(b4.ready_in), 128'd1);
      check("rst_valid_out", 128'(b4.valid_out), 128'd0);
      check("rst_busy", 128'(b4.busy), 128'd0);
      check("rst_data_out", b4.data_out, 128'd0);
      check("rst_ready_in_l16", 128'(b16.ready_in), 128'd1);

      // All-zero state, forward
      run_block(0, '0, 1'b0, dout, lat);
      check("zero_latency", 128'(lat), 128'd4);
      check("zero_data", dout, All63);
      check("done_busy", 128'(b4.busy), 128'd0);
      consume(0);
      check("xfer_valid_out", 128'(b4.valid_out), 128'd0);
      check("xfer_ready_in", 128'(b4.ready_in), 128'd1);

      // Ascending bytes, forward
      run_block(0, In2, 1'b0, dout, lat);
      check("fwd_latency", 128'(lat), 128'd4);
      check("fwd_data", dout, Out2);
      consume(0);

      // Inverse round trip and single-byte inverse values
      run_block(0, Out2, 1'b1, dout, lat);
      check("inv_data", dout, In2);
      consume(0);
      run_block(0, InSgl, 1'b1, dout, lat);
      check("inv_single", dout, OutSgl);
      consume(0);

      // Back-pressure: hold in DONE while a new block is offered
      run_block(0, In2, 1'b0, dout, lat);
      drive(0, 1'b1, 1'b0, '0);
      for (int c = 0; c < 10; c++) begin
         check("hold_valid_out", 128'(b4.valid_out), 128'd1);
         check("hold_data_out", b4.data_out, Out2);
         check("hold_ready_in", 128'(b4.ready_in), 128'd0);
         @(posedge clk);
         #1;
      end
      set_ready_out(0, 1'b1);
      #1;
      check("release_ready_in", 128'(b4.ready_in), 128'd1);
      @(posedge clk);
      #1;
      set_ready_out(0, 1'b0);
      drive(0, 1'b0, 1'b0, '0);
      check("nobubble_valid_out", 128'(b4.valid_out), 128'd0);
      check("nobubble_busy", 128'(b4.busy), 128'd1);
      wait_valid(0, lat);
      check("nobubble_latency", 128'(lat), 128'd4);
      check("nobubble_data", b4.data_out, All63);
      consume(0);

      // Reset mid-block with the slice counter at 2
      drive(0, 1'b1, 1'b0, In2);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, '0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("midrst_busy_before", 128'(b4.busy), 128'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      check("midrst_busy", 128'(b4.busy), 128'd0);
      check("midrst_valid_out", 128'(b4.valid_out), 128'd0);
      check("midrst_data_out", b4.data_out, 128'd0);
      check("midrst_ready_in", 128'(b4.ready_in), 128'd1);
      run_block(0, In2, 1'b0, dout, lat);
      check("postrst_latency", 128'(lat), 128'd4);
      check("postrst_data", dout, Out2);
      consume(0);

      // LANES=1 and LANES=16 against the table model
      for (int s = 1; s < 3; s++) begin
         for (int v = 0; v < 4; v++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(s, d, v[0], dout, lat);
            check((s == 1) ? "l1_latency" : "l16_latency", 128'(lat), (s == 1) ? 128'd16 : 128'd1);
            check((s == 1) ? "l1_data" : "l16_data", dout, ref_sub(d, v[0]));
            consume(s);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
